// File: rtl/fetch_queue.sv
// Fetch stage with a credit-limited request path to instruction memory and a
// DEPTH-entry {pc, instr} queue that drains to decode; redirect flushes both.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int              AW    = $clog2(DEPTH);
  localparam int              CW    = AW + 1;
  localparam logic [CW:0]     LIMIT = (CW+1)'(DEPTH);

  // Handshakes: a transfer occurs on a rising edge where valid && ready;
  // valid never depends on ready, and a redirect cycle cancels both the
  // outgoing request and any pop.
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW:0]     credit_used;
  logic            accept;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used    = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = rst && !redirect && (credit_used < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take       = imem_rsp_valid && (inflight != '0);
  assign rsp_drop       = rsp_take && (drop != '0);
  assign push           = rsp_take && !rsp_drop && !redirect;
  assign out_valid      = (count != '0);
  assign pop            = out_valid && out_ready && !redirect;
  assign out_pc         = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr      = out_valid ? mem_instr[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(rsp_take);
      if (redirect) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        drop     <= inflight - CW'(rsp_take);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_drop) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= rsp_pc;
      mem_instr[wr_ptr] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order variable-latency memory model
// feeds the DUT, and a monitor checks every popped entry against exp_q.
module tb_fetch_queue;
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit stray    = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  // clock
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory model: capture accepted requests, answer in order after lat cycles
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr.pop_front() ^ KEY;
        void'(pend_due.pop_front());
      end else if (stray) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_1234;
        stray          = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, e ^ KEY);
      end
    end
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b1; lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);

    // free run: six requests at 1-cycle latency, then memory stalls
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("free_out_valid", 32'(out_valid), 32'(i >= 2));
      if (i < 6) begin
        chk("free_req_valid", 32'(imem_req_valid), 32'd1);
        chk("free_req_addr", imem_req_addr, 32'(4 * i));
      end
      tick();
      if (i == 5) imem_req_ready = 1'b0;
    end

    // memory stall: address held, fetch_pc not advanced
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'd24);
      chk("stall_count", 32'(count), 32'd0);
      tick();
    end

    // backpressure: queue fills to DEPTH, then drains in order without gaps
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd24 + 32'(4 * i));
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("bp_credit", 32'((pend_addr.size() + int'(imem_rsp_valid) + int'(count)) <= 4), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    out_ready = 1'b1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_count", 32'(count), 32'(4 - i));
      chk("drain_out_valid", 32'(out_valid), 32'(i < 4));
      tick();
    end

    // redirect with two requests in flight at 3-cycle latency
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    lat = 3;
    imem_req_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_req_valid1", 32'(imem_req_valid), 32'd1);
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("redir_req_addr2", imem_req_addr, 32'h104);
    tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("redir_count_end", 32'(count), 32'd0);

    // redirect coincident with an arriving response and a pop; target wraps
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick();
    lat = 1;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    out_ready = 1'b1;
    @(negedge clk);
    chk("coin_count_before", 32'(count), 32'd1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("coin_count_after", 32'(count), 32'd0);
    chk("coin_out_valid", 32'(out_valid), 32'd0);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    chk("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_addr2", imem_req_addr, 32'h0000_0000);
    tick();
    imem_req_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("wrap_count_end", 32'(count), 32'd0);

    // reset mid-operation, then a stray response with nothing outstanding
    tick();
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_out_pc", out_pc, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'd0);
    chk("stray_count0", 32'(count), 32'd0);
    tick();
    @(negedge clk);
    chk("stray_count1", 32'(count), 32'd0);
    chk("stray_out_valid", 32'(out_valid), 32'd0);
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
